// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: parity-mode codes, frame state encoding and a parity helper.
// Kept free of transmitter specifics so a receiver can import the same encodings.
package uart_tx_buffered_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; data visible at the head combinationally.
// Push while full and pop while empty are ignored; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only reachable through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a word pushed into an empty idle FIFO starts its start bit one edge later.
// Pushes while full are dropped and flagged in the sticky overflow bit; frames run back to back.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DIVISOR    = 2604,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          clr_ovf,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          txd
);

    localparam int BAUD_W = $clog2(DIVISOR);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_state_t            state, state_n;
    logic [BAUD_W-1:0]      baud_cnt, baud_n;
    logic [BIT_W-1:0]       bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   par_q, par_n;
    logic                   txd_n;
    logic                   bit_end;
    logic                   load;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   head_data;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign busy    = (state != ST_IDLE);
    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        par_n    = par_q;
        txd_n    = txd;
        load     = 1'b0;
        fifo_pop = 1'b0;

        if (state != ST_IDLE) begin
            baud_n = bit_end ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            ST_IDLE: begin
                txd_n = 1'b1;
                if (!empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    txd_n   = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
                        if (PARITY != PAR_NONE) begin
                            state_n = ST_PAR;
                            txd_n   = par_q;
                        end else begin
                            state_n = ST_STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + BIT_W'(1);
                        shift_n = shift >> 1;
                        txd_n   = shift[1];
                    end
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    txd_n   = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_n = '0;
                        // A waiting word starts on this very edge so frames abut.
                        if (!empty) load    = 1'b1;
                        else        state_n = ST_IDLE;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                txd_n   = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            state_n  = ST_START;
            shift_n  = head_data;
            par_n    = parity_bit(8'(head_data), PARITY);
            txd_n    = 1'b0;
            baud_n   = '0;
            bit_n    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            txd      <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par_q    <= par_n;
            txd      <= txd_n;
        end
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
